// File: rtl/csa_pkg.sv
// csa_pkg: shared definitions for the pipelined conditional-sum adder.
//   csa_stages(n, slice) : number of pipeline stages (one per slice)
//   csa_cfg_ok(n, slice) : legality of an (N, SLICE) pair
//   SAT_MAX(n), SAT_MIN(n): signed saturation limits for an n-bit result,
//                           returned LSB-aligned in a CSA_MAX_W-bit vector
package csa_pkg;

  localparam int unsigned CSA_MAX_W = 1024;

  function automatic int unsigned csa_stages(input int unsigned n, input int unsigned slice);
    return (slice == 0) ? 0 : n / slice;
  endfunction

  function automatic bit csa_cfg_ok(input int unsigned n, input int unsigned slice);
    int unsigned div;
    div = (slice >= 1) ? slice : 1;
    return (slice >= 1) && (n >= slice) && ((n % div) == 0);
  endfunction

  function automatic logic [CSA_MAX_W-1:0] SAT_MAX(input int unsigned n);
    logic [CSA_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i + 1 < n; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [CSA_MAX_W-1:0] SAT_MIN(input int unsigned n);
    logic [CSA_MAX_W-1:0] r;
    r = '0;
    if (n >= 1) r[n-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/csa_slice.sv
// csa_slice: combinational SLICE-bit dual-carry adder.
//   a, b       : slice operands
//   sum0, co0  : result and carry-out assuming carry-in 0
//   sum1, co1  : result and carry-out assuming carry-in 1
// Recursive half-split conditional-sum structure: the low half's two
// carries select between the high half's two precomputed results; the
// leaves are full adders with constant carry-in.
module csa_slice
  import csa_pkg::*;
#(
  parameter int unsigned SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] sum0,
  output logic [SLICE-1:0] sum1,
  output logic             co0,
  output logic             co1
);

  if (SLICE == 1) begin : g_leaf
    assign sum0 = a ^ b;
    assign co0  = a & b;
    assign sum1 = ~(a ^ b);
    assign co1  = a | b;
  end else begin : g_split
    localparam int unsigned LW = SLICE / 2;
    localparam int unsigned HW = SLICE - LW;

    logic [LW-1:0] lo_s0, lo_s1;
    logic [HW-1:0] hi_s0, hi_s1;
    logic          lo_c0, lo_c1, hi_c0, hi_c1;

    csa_slice #(.SLICE(LW)) u_lo (
      .a(a[LW-1:0]), .b(b[LW-1:0]),
      .sum0(lo_s0), .sum1(lo_s1), .co0(lo_c0), .co1(lo_c1)
    );

    csa_slice #(.SLICE(HW)) u_hi (
      .a(a[SLICE-1:LW]), .b(b[SLICE-1:LW]),
      .sum0(hi_s0), .sum1(hi_s1), .co0(hi_c0), .co1(hi_c1)
    );

    assign sum0 = {lo_c0 ? hi_s1 : hi_s0, lo_s0};
    assign co0  = lo_c0 ? hi_c1 : hi_c0;
    assign sum1 = {lo_c1 ? hi_s1 : hi_s0, lo_s1};
    assign co1  = lo_c1 ? hi_c1 : hi_c0;
  end

endmodule

// File: rtl/csa_pipe.sv
// csa_pipe: pipelined conditional-sum adder/subtractor, one slice per stage.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = ~stall, combinational)
//   a, b, ci, sub        : operands; sub=1 computes a + ~b + 1 and ignores ci
//   sat                  : clamp on signed overflow (only with CSA_PIPE_SAT_EN)
//   out_valid / out_ready: result handshake with full backpressure
//   sum, co, ovf         : result, unsigned carry-out (1 = no borrow), signed overflow
// Optional feature macro: CSA_PIPE_SAT_EN adds the sat input and clamping.
// Latency STAGES = N/SLICE cycles, throughput one result per cycle.
module csa_pipe
  import csa_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  input  logic         sub,
`ifdef CSA_PIPE_SAT_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         ovf
);

  localparam int unsigned STAGES = csa_stages(N, SLICE);
  localparam int unsigned LAST   = STAGES - 1;

  if (!csa_cfg_ok(N, SLICE)) begin : g_bad_cfg
    $error("csa_pipe: N must be a positive multiple of SLICE");
  end

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // Stage k: x_q holds finished result bits below slice k and raw A bits
  // from slice k up; b_q holds only the B bits not yet consumed (skew buffer).
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO  = k * SLICE;
    localparam int unsigned REM = N - LO;

    logic             v_q, c_q;
    logic [N-1:0]     x_q;
    logic [REM-1:0]   b_q;
`ifdef CSA_PIPE_SAT_EN
    logic             s_q;
`endif
    logic [SLICE-1:0] s0, s1, s_sel;
    logic             k0, k1, c_sel;
    logic [N-1:0]     x_nxt;

    csa_slice #(.SLICE(SLICE)) u_slice (
      .a(x_q[LO +: SLICE]), .b(b_q[SLICE-1:0]),
      .sum0(s0), .sum1(s1), .co0(k0), .co1(k1)
    );

    assign s_sel = c_q ? s1 : s0;
    assign c_sel = c_q ? k1 : k0;

    always_comb begin
      x_nxt             = x_q;
      x_nxt[LO +: SLICE] = s_sel;
    end

    if (k == 0) begin : g_cap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v_q <= 1'b0;
        else if (adv) v_q <= in_valid;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          x_q <= a;
          b_q <= sub ? ~b : b;
          c_q <= sub | ci;
`ifdef CSA_PIPE_SAT_EN
          s_q <= sat;
`endif
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   v_q <= 1'b0;
        else if (adv) v_q <= g_stg[k-1].v_q;
      end

      always_ff @(posedge clk) begin
        if (adv) begin
          x_q <= g_stg[k-1].x_nxt;
          b_q <= g_stg[k-1].b_q[REM+SLICE-1:SLICE];
          c_q <= g_stg[k-1].c_sel;
`ifdef CSA_PIPE_SAT_EN
          s_q <= g_stg[k-1].s_q;
`endif
        end
      end
    end
  end

  logic [N-1:0] res, res_final;
  logic         res_co, res_ovf, c_msb_in;

  assign res      = g_stg[LAST].x_nxt;
  assign res_co   = g_stg[LAST].c_sel;
  // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ cin.
  assign c_msb_in = g_stg[LAST].x_q[N-1] ^ g_stg[LAST].b_q[SLICE-1] ^ res[N-1];
  assign res_ovf  = c_msb_in ^ res_co;

`ifdef CSA_PIPE_SAT_EN
  localparam logic [N-1:0] SAT_HI = N'(SAT_MAX(N));
  localparam logic [N-1:0] SAT_LO = N'(SAT_MIN(N));

  // On overflow the wrapped MSB is the inverse of the true sign.
  always_comb begin
    res_final = res;
    if (g_stg[LAST].s_q && res_ovf) res_final = res[N-1] ? SAT_HI : SAT_LO;
  end
`else
  assign res_final = res;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv) begin
      out_valid <= g_stg[LAST].v_q;
      if (g_stg[LAST].v_q) begin
        sum <= res_final;
        co  <= res_co;
        ovf <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe.sv
module tb_csa_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [31:0] a, b, sum;
`ifdef CSA_PIPE_SAT_EN
  logic        sat_i;
`endif

  csa_pipe #(.N(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
`ifdef CSA_PIPE_SAT_EN
    .sat(sat_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  // Extra configurations for the random sweep, never back-pressured.
  logic        sw_valid, sw_ci, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic [63:0] sw_sum [3];
  logic        sw_ov [3];
  logic        sw_co [3];
  logic        sw_ovf [3];
  logic        sw_ir [3];

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int unsigned W  = (g == 0) ? 8 : ((g == 1) ? 16 : 64);
    localparam int unsigned SL = (g == 0) ? 8 : ((g == 1) ? 4 : 16);
    logic [W-1:0] s_loc;
    logic         ov_l, co_l, ovf_l, ir_l;
    csa_pipe #(.N(W), .SLICE(SL)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir_l),
      .a(sw_a[W-1:0]), .b(sw_b[W-1:0]), .ci(sw_ci), .sub(sw_sub),
`ifdef CSA_PIPE_SAT_EN
      .sat(1'b0),
`endif
      .out_valid(ov_l), .out_ready(1'b1), .sum(s_loc), .co(co_l), .ovf(ovf_l)
    );
    assign sw_sum[g] = 64'(s_loc);
    assign sw_ov[g]  = ov_l;
    assign sw_co[g]  = co_l;
    assign sw_ovf[g] = ovf_l;
    assign sw_ir[g]  = ir_l;
  end

  typedef struct {
    logic [65:0] exp;
    int unsigned acc;
    int unsigned tag;
  } sb_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
`ifdef CSA_PIPE_SAT_EN
    logic        sat;
`endif
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  sb_t         q_m [$];
  sb_t         q_s [3][$];
  vec_t        vt [$];
  int unsigned n_chk = 0, n_fail = 0, cyc = 0, tagc = 0;
  int unsigned pops, first_pop, last_pop, stale;
  logic [65:0] cur_exp, held;
  bit          sb_en = 0, lat_chk = 0, m_acc = 0;

  function automatic int unsigned sw_n(input int unsigned g);
    return (g == 0) ? 8 : ((g == 1) ? 16 : 64);
  endfunction

  // Behavioural reference: {ovf, co, sum} for an n-bit add/subtract.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input int unsigned n, input logic s, input logic c);
    logic [64:0] m, xx, yy, r;
    m  = (65'd1 << n) - 65'd1;
    xx = {1'b0, x} & m;
    yy = (s ? ~{1'b0, y} : {1'b0, y}) & m;
    r  = xx + yy + {64'd0, (s ? 1'b1 : c)};
    return {(xx[n-1] == yy[n-1]) && (r[n-1] != xx[n-1]), r[n], 64'(r & m)};
  endfunction

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic sb_step();
    sb_t e;
    m_acc = in_valid && in_ready;
    if (m_acc) begin
      e.exp = cur_exp; e.acc = cyc + 1; e.tag = tagc; tagc++;
      q_m.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (q_m.size() == 0) check("unexpected_out_valid", 66'(out_valid), 66'(0));
      else begin
        e = q_m.pop_front();
        check($sformatf("result_%0d", e.tag), {ovf, co, 32'h0, sum}, e.exp);
        if (lat_chk) check($sformatf("latency_%0d", e.tag), 66'(cyc - e.acc), 66'(4));
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
    for (int unsigned g = 0; g < 3; g++) begin
      if (sw_valid && sw_ir[g]) begin
        e.exp = model(sw_a, sw_b, sw_n(g), sw_sub, sw_ci); e.acc = cyc + 1; e.tag = tagc; tagc++;
        q_s[g].push_back(e);
      end
      if (sw_ov[g]) begin
        if (q_s[g].size() == 0) check($sformatf("sw%0d_unexpected_out_valid", g), 66'(sw_ov[g]), 66'(0));
        else begin
          e = q_s[g].pop_front();
          check($sformatf("sw%0d_result_%0d", g, e.tag), {sw_ovf[g], sw_co[g], sw_sum[g]}, e.exp);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (sb_en) sb_step();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic c);
    in_valid = 1'b1; a = x; b = y; sub = s; ci = c;
    cur_exp = model(64'(x), 64'(y), 32, s, c);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0; cur_exp = '0;
`ifdef CSA_PIPE_SAT_EN
    sat_i = 1'b0;
`endif

    vt.push_back('{a:32'h0000_00FF, b:32'h0000_0001, ci:1'b0, sub:1'b0, s:32'h0000_0100, c:1'b0, v:1'b0, default:'0});
    vt.push_back('{a:32'hFFFF_FFFF, b:32'h0000_0001, ci:1'b0, sub:1'b0, s:32'h0000_0000, c:1'b1, v:1'b0, default:'0});
    vt.push_back('{a:32'h0000_0005, b:32'h0000_0007, ci:1'b0, sub:1'b1, s:32'hFFFF_FFFE, c:1'b0, v:1'b0, default:'0});
    vt.push_back('{a:32'h8000_0000, b:32'h0000_0001, ci:1'b0, sub:1'b1, s:32'h7FFF_FFFF, c:1'b1, v:1'b1, default:'0});
    vt.push_back('{a:32'h7FFF_FFFF, b:32'h0000_0001, ci:1'b0, sub:1'b0, s:32'h8000_0000, c:1'b0, v:1'b1, default:'0});
    vt.push_back('{a:32'h1234_5678, b:32'h1111_1111, ci:1'b1, sub:1'b0, s:32'h2345_678A, c:1'b0, v:1'b0, default:'0});
    vt.push_back('{a:32'h0000_000A, b:32'h0000_0003, ci:1'b1, sub:1'b1, s:32'h0000_0007, c:1'b1, v:1'b0, default:'0});
    vt.push_back('{a:32'h00FF_FFFF, b:32'h0000_0001, ci:1'b0, sub:1'b0, s:32'h0100_0000, c:1'b0, v:1'b0, default:'0});
    vt.push_back('{a:32'hFFFF_FFFF, b:32'hFFFF_FFFF, ci:1'b1, sub:1'b0, s:32'hFFFF_FFFF, c:1'b1, v:1'b0, default:'0});
    vt.push_back('{a:32'h8000_0000, b:32'h8000_0000, ci:1'b0, sub:1'b0, s:32'h0000_0000, c:1'b1, v:1'b1, default:'0});
`ifdef CSA_PIPE_SAT_EN
    vt.push_back('{a:32'h7FFF_FFFF, b:32'h0000_0001, ci:1'b0, sub:1'b0, sat:1'b1, s:32'h7FFF_FFFF, c:1'b0, v:1'b1});
    vt.push_back('{a:32'h8000_0000, b:32'h0000_0001, ci:1'b0, sub:1'b1, sat:1'b1, s:32'h8000_0000, c:1'b1, v:1'b1});
`endif

    // Reset state, both during and just after reset.
    repeat (2) tick();
    check("rst_out_valid", 66'(out_valid), 66'(0));
    check("rst_in_ready", 66'(in_ready), 66'(1));
    check("rst_outputs", {ovf, co, 32'h0, sum}, 66'(0));
    rst_n = 1'b1;
    tick();
    check("post_rst_out_valid", 66'(out_valid), 66'(0));
    check("post_rst_in_ready", 66'(in_ready), 66'(1));

    // Directed table, back to back, with latency and one-per-cycle checks.
    sb_en = 1; lat_chk = 1; pops = 0;
    for (int i = 0; i < vt.size(); i++) begin
      in_valid = 1'b1; a = vt[i].a; b = vt[i].b; ci = vt[i].ci; sub = vt[i].sub;
`ifdef CSA_PIPE_SAT_EN
      sat_i = vt[i].sat;
`endif
      cur_exp = {vt[i].v, vt[i].c, 32'h0, vt[i].s};
      tick();
    end
    in_valid = 1'b0;
`ifdef CSA_PIPE_SAT_EN
    sat_i = 1'b0;
`endif
    repeat (8) tick();
    check("table_count", 66'(pops), 66'(vt.size()));
    check("table_back_to_back", 66'(last_pop - first_pop), 66'(vt.size() - 1));
    lat_chk = 0;

    // Backpressure: 4 in flight, 3 stalled cycles with a new op waiting.
    pops = 0;
    for (int i = 0; i < 4; i++) begin
      drive_op(32'h1000 * i + 32'd3, 32'h777 * i + 32'd9, i[0], 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("bp_out_valid_before_stall", 66'(out_valid), 66'(1));
    out_ready = 1'b0;
    drive_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0, 1'b0);
    held = {ovf, co, 32'h0, sum};
    #1;
    check("bp_in_ready_stall", 66'(in_ready), 66'(0));
    for (int j = 0; j < 3; j++) begin
      tick();
      check($sformatf("bp_in_ready_%0d", j), 66'(in_ready), 66'(0));
      check($sformatf("bp_out_valid_%0d", j), 66'(out_valid), 66'(1));
      check($sformatf("bp_stable_%0d", j), {ovf, co, 32'h0, sum}, held);
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("bp_result_count", 66'(pops), 66'(5));
    check("bp_queue_empty", 66'(q_m.size()), 66'(0));

    // Reset with 3 operations in flight.
    for (int i = 0; i < 3; i++) begin
      drive_op(32'h0101_0101 * (i + 1), 32'h0F0F_0F0F, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    repeat (2) tick();
    check("mid_rst_out_valid_before", 66'(out_valid), 66'(1));
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 66'(out_valid), 66'(0));
    check("mid_rst_in_ready", 66'(in_ready), 66'(1));
    check("mid_rst_sum", 66'(sum), 66'(0));
    q_m.delete();
    tick();
    #2 rst_n = 1'b1;
    #1;
    check("after_rst_in_ready", 66'(in_ready), 66'(1));
    stale = 0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (out_valid) stale++;
    end
    check("after_rst_no_stale", 66'(stale), 66'(0));

    // Random sweep: main DUT with random backpressure, others free-running.
    m_acc = 0;
    for (int j = 0; j < 300; j++) begin
      if (!in_valid || m_acc) begin
        drive_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      sw_valid  = ($urandom_range(0, 3) != 0);
      sw_a      = {$urandom, $urandom};
      sw_b      = {$urandom, $urandom};
      sw_sub    = 1'($urandom_range(0, 1));
      sw_ci     = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; sw_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
    check("sweep_main_drained", 66'(q_m.size()), 66'(0));
    for (int g = 0; g < 3; g++)
      check($sformatf("sweep_sw%0d_drained", g), 66'(q_s[g].size()), 66'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_pipe.md
# csa_pipe

Pipelined, parametrised conditional-sum adder/subtractor for the datapath lab designs. Operands are split into equal slices, and each pipeline stage resolves one slice. Each slice precomputes its sum for carry-in 0 and carry-in 1, then selects one using the carry registered from the previous stage. A valid/ready handshake with full backpressure lets it sit between register stages. It produces one result per cycle at a latency of one cycle per slice.

## Interface
Parameters:
- `N`, 32, operand width in bits; must be a multiple of `SLICE`.
- `SLICE`, 8, bits resolved per stage; `STAGES = N/SLICE` is derived and is at least 1.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: an operand set is presented.
- `in_ready` output 1: the block accepts the operand set this cycle.
- `a` input N: operand A, unsigned or two's complement.
- `b` input N: operand B.
- `ci` input 1: carry-in; ignored when `sub`=1.
- `sub` input 1: 0 computes A+B+ci; 1 computes A−B, i.e. A+~B+1.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer takes the result.
- `sum` output N: result.
- `co` output 1: unsigned carry-out. For subtraction, `co`=1 means no borrow.
- `ovf` output 1: signed overflow, computed as carry into the MSB XOR carry out of the MSB.

## Operation
- Slice k covers bits `[k*SLICE +: SLICE]`.
- Stage k holds a valid bit, the registered carry into slice k, finished result bits for slices 0..k−1, and the raw operand bits for slices k..STAGES−1 (skew buffering).
- Inside stage k, the `csa_slice` instance computes `{co0,sum0}` with carry-in 0 and `{co1,sum1}` with carry-in 1. The registered carry selects between them, and the selected carry-out is registered into stage k+1.
- Stage 0's carry-in is `sub ? 1 : ci`. The B operand is inverted at capture when `sub`=1.
- `ovf` is taken from the last slice: `c_msb_in ^ co`, where `c_msb_in` is the carry into bit N−1.
- Flow control is a global stall:
  - `stall = out_valid & ~out_ready`.
  - While stalling, every stage holds its contents.
  - `in_ready = ~stall`.
  - A transfer occurs on `in_valid & in_ready`.
  - Bubbles are not compressed: stages shift together when the pipeline is not stalled.
- When a stage receives no transfer, its valid bit clears.
- Data registers do not need a reset; valid bits do.

## Timing
- Latency: a result accepted at edge t appears with `out_valid`=1 after edge t+STAGES, i.e. at edge t+STAGES−1 plus one more edge.
- Throughput: one result per cycle while `out_ready`=1.
- Reset values: `out_valid`=0, `in_ready`=1, `sum`=0, `co`=0, `ovf`=0. All stage valid bits are 0.
- Reset asserted mid-operation flushes every in-flight operation immediately and asynchronously. No result is produced for operations accepted before reset.
- While `out_valid`=1 and `out_ready`=0, `sum`, `co` and `ovf` hold stable.
- When a stall and `in_valid` occur together, the input is not accepted, and the producer must hold it.
- `in_ready` depends combinationally on `out_ready`. This is the documented path.
- With `STAGES`=1 the block degenerates to one conditional-sum slice plus one output register.
- Wrap-around: 0xFFFF_FFFF+1 gives `sum`=0, `co`=1 with no error.

## Configuration
- `CSA_PIPE_SAT_EN`, when defined:
  - Adds input `sat` (1 bit), captured with the operands.
  - When `sat`=1 and `ovf`=1, `sum` is clamped to the signed limit: 0x7FF…F if the true result is positive, 0x800…0 if negative.
  - `ovf` still reports the overflow.
- Without the macro, the `sat` port does not exist and `sum` is always the wrapped result.
- Latency is unchanged in both builds; clamping happens in the last stage.

## Structure
- Shared package `csa_pkg` holds:
  - The function deriving `STAGES`.
  - The elaboration checks `N % SLICE == 0` and `SLICE >= 1`.
  - The saturation constants `SAT_MAX(N)` and `SAT_MIN(N)`.
- Sub-module `csa_slice`: a combinational, parametrised `SLICE`-bit dual-carry adder producing `sum0`, `sum1`, `co0`, `co1`. It is built internally as the recursive half-split conditional-sum structure on full adders.
- `csa_pipe` contains the skew registers, stage valid bits and stall logic, with one `csa_slice` per stage.

## Test plan
- N=32, SLICE=8, back-to-back stream with `out_ready`=1:
  - 0x0000_00FF + 0x0000_0001 gives `sum`=0x0000_0100 at latency 4.
  - 0xFFFF_FFFF + 0x1 gives `sum`=0, `co`=1.
  - One result appears per cycle.
- Subtraction: `sub`=1, 5−7 gives `sum`=0xFFFF_FFFE, `co`=0, `ovf`=0. A second case, 0x8000_0000−1, gives `sum`=0x7FFF_FFFF and `ovf`=1.
- Backpressure: hold `out_ready`=0 for 3 cycles with 4 operations in flight.
  - `in_ready`=0 throughout the stall and outputs stay stable.
  - After release, the results emerge in order and none are lost or duplicated.
- Reset mid-stream: pull `rst_n` low with 3 operations in flight.
  - `out_valid` drops to 0 immediately.
  - After release, `in_ready`=1 and no stale results appear.
- `CSA_PIPE_SAT_EN` build, `sat`=1:
  - 0x7FFF_FFFF + 1 gives `sum`=0x7FFF_FFFF with `ovf`=1.
  - 0x8000_0000 − 1 gives `sum`=0x8000_0000.
  - With `sat`=0, the same operations wrap.
- Randomised sweep across (N, SLICE) = (8,8), (16,4), (32,8) and (64,16): compare against a behavioural `a + (sub ? ~b : b) + cin` model.
